// File: rtl/red_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : red_seq_ctrl                                                    |
// | Brief  : 4-cycle sequencer for ADDI/ADD/SUB/BNE driving the red_top      |
// |          datapath. Optional macro RED_SEQ_ILLEGAL_TRAP_EN parks the FSM  |
// |          in a trap state on an illegal opcode.                           |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module red_seq_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    input  logic [DATA_WIDTH-1:0] instr_in,
    output logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] Instr,
    output logic                  ALUsrc,
    output logic [2:0]            ALUctrl,
    output logic [DATA_WIDTH-1:0] ImmOp,
    output logic                  RegWrite,
    input  logic                  EQ,
    output logic                  branch_valid,
    output logic                  branch_taken,
    output logic                  done,
    output logic                  illegal
);

    localparam logic [6:0] c_OPC_IMM    = 7'b0010011;
    localparam logic [6:0] c_OPC_REG    = 7'b0110011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [2:0] c_ALU_ADD    = 3'b000;
    localparam logic [2:0] c_ALU_SUB    = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_TRAP   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        K_WRITE  = 2'd0,
        K_BRANCH = 2'd1,
        K_NOP    = 2'd2
    } kind_t;

    state_t                r_state;
    kind_t                 r_kind;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_instr;
    logic                  r_alusrc;
    logic [2:0]            r_aluctrl;
    logic [DATA_WIDTH-1:0] r_imm;
    logic                  r_regwrite;
    logic                  r_bvalid;
    logic                  r_btaken;
    logic                  r_done;
    logic                  r_illegal;

    logic                  w_is_addi;
    logic                  w_is_add;
    logic                  w_is_sub;
    logic                  w_is_bne;
    logic [DATA_WIDTH-1:0] w_imm_i;
    logic [DATA_WIDTH-1:0] w_imm_b;

    // Decode works on the held instruction, so fields stay valid through DECODE.
    always_comb begin
        w_is_addi = (r_instr[6:0] == c_OPC_IMM) && (r_instr[14:12] == 3'b000);
        w_is_add  = (r_instr[6:0] == c_OPC_REG) && (r_instr[14:12] == 3'b000)
                    && (r_instr[31:25] == 7'b0000000);
        w_is_sub  = (r_instr[6:0] == c_OPC_REG) && (r_instr[14:12] == 3'b000)
                    && (r_instr[31:25] == 7'b0100000);
        w_is_bne  = (r_instr[6:0] == c_OPC_BRANCH) && (r_instr[14:12] == 3'b001);
        w_imm_i   = {{(DATA_WIDTH-12){r_instr[31]}}, r_instr[31:20]};
        w_imm_b   = {{(DATA_WIDTH-13){r_instr[31]}}, r_instr[31], r_instr[7],
                     r_instr[30:25], r_instr[11:8], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_kind     <= K_NOP;
            r_ready    <= 1'b0;
            r_instr    <= '0;
            r_alusrc   <= 1'b0;
            r_aluctrl  <= c_ALU_ADD;
            r_imm      <= '0;
            r_regwrite <= 1'b0;
            r_bvalid   <= 1'b0;
            r_btaken   <= 1'b0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_regwrite <= 1'b0;
            r_bvalid   <= 1'b0;
            r_btaken   <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Ready comes up one cycle after reset release, then stays up.
                    if (r_ready && instr_valid) begin
                        r_instr <= instr_in;
                        r_ready <= 1'b0;
                        r_state <= S_DECODE;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (w_is_addi) begin
                        r_alusrc  <= 1'b1;
                        r_aluctrl <= c_ALU_ADD;
                        r_imm     <= w_imm_i;
                        r_kind    <= K_WRITE;
                    end else if (w_is_add || w_is_sub) begin
                        r_alusrc  <= 1'b0;
                        r_aluctrl <= w_is_sub ? c_ALU_SUB : c_ALU_ADD;
                        r_imm     <= '0;
                        r_kind    <= K_WRITE;
                    end else if (w_is_bne) begin
                        r_alusrc  <= 1'b0;
                        r_aluctrl <= c_ALU_SUB;
                        r_imm     <= w_imm_b;
                        r_kind    <= K_BRANCH;
                    end else begin
                        r_alusrc  <= 1'b0;
                        r_aluctrl <= c_ALU_ADD;
                        r_imm     <= '0;
                        r_kind    <= K_NOP;
                    end
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    // Pulses registered here are visible during the WB cycle.
                    case (r_kind)
                        K_WRITE:  r_regwrite <= 1'b1;
                        K_BRANCH: begin
                            r_bvalid <= 1'b1;
                            r_btaken <= ~EQ;
                        end
                        default: begin
`ifdef RED_SEQ_ILLEGAL_TRAP_EN
                            r_illegal <= 1'b1;
`endif
                        end
                    endcase
                    r_done  <= 1'b1;
                    r_state <= S_WB;
                end
                S_WB: begin
`ifdef RED_SEQ_ILLEGAL_TRAP_EN
                    if (r_kind == K_NOP) begin
                        r_state <= S_TRAP;
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
`else
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
`endif
                end
                S_TRAP: begin
                    r_ready <= 1'b0;
                    r_state <= S_TRAP;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready  = r_ready;
    assign Instr        = r_instr;
    assign ALUsrc       = r_alusrc;
    assign ALUctrl      = r_aluctrl;
    assign ImmOp        = r_imm;
    assign RegWrite     = r_regwrite;
    assign branch_valid = r_bvalid;
    assign branch_taken = r_btaken;
    assign done         = r_done;
    assign illegal      = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_red_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_red_seq_ctrl                                                 |
// | Brief  : Vector-table bench for red_seq_ctrl plus multi-cycle sequences. |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_red_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr_in;
    logic        instr_ready;
    logic [31:0] Instr;
    logic        ALUsrc;
    logic [2:0]  ALUctrl;
    logic [31:0] ImmOp;
    logic        RegWrite;
    logic        EQ;
    logic        branch_valid;
    logic        branch_taken;
    logic        done;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    red_seq_ctrl #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_in     (instr_in),
        .instr_ready  (instr_ready),
        .Instr        (Instr),
        .ALUsrc       (ALUsrc),
        .ALUctrl      (ALUctrl),
        .ImmOp        (ImmOp),
        .RegWrite     (RegWrite),
        .EQ           (EQ),
        .branch_valid (branch_valid),
        .branch_taken (branch_taken),
        .done         (done),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        eq;
        logic        alusrc;
        logic [2:0]  aluctrl;
        logic [31:0] imm;
        logic        rw;
        logic        bv;
        logic        bt;
        logic        ill;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    // Handshake one instruction and check every cycle up to the return to IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        int n;
        n = 0;
        @(negedge clk);
        instr_in    = v.instr;
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", idx, {31'd0, instr_ready}, 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        instr_in    = 32'hDEAD_BEEF;
        check("decode_instr", idx, Instr, v.instr);
        check("decode_ready", idx, {31'd0, instr_ready}, 32'd0);
        check("decode_rw", idx, {31'd0, RegWrite}, 32'd0);
        @(negedge clk);
        EQ = v.eq;
        if (!v.ill) begin
            check("alusrc", idx, {31'd0, ALUsrc}, {31'd0, v.alusrc});
            check("aluctrl", idx, {29'd0, ALUctrl}, {29'd0, v.aluctrl});
            if (v.alusrc || v.bv)
                check("immop", idx, ImmOp, v.imm);
        end
        check("exec_rw", idx, {31'd0, RegWrite}, 32'd0);
        @(negedge clk);
        check("wb_rw", idx, {31'd0, RegWrite}, {31'd0, v.rw});
        check("wb_bvalid", idx, {31'd0, branch_valid}, {31'd0, v.bv});
        if (v.bv)
            check("wb_btaken", idx, {31'd0, branch_taken}, {31'd0, v.bt});
        check("wb_done", idx, {31'd0, done}, 32'd1);
        check("wb_illegal", idx, {31'd0, illegal}, {31'd0, v.ill});
        check("wb_instr_held", idx, Instr, v.instr);
        @(negedge clk);
        EQ = 1'b0;
        check("post_rw", idx, {31'd0, RegWrite}, 32'd0);
        check("post_done", idx, {31'd0, done}, 32'd0);
        check("post_ready", idx, {31'd0, instr_ready}, {31'd0, ~v.ill});
    endtask

    initial begin
        int t1, t2, ndone, nrw, n;
        vec_t v;

        vecs[0] = '{32'h0050_0513, 1'b0, 1'b1, 3'b000, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFF0_0513, 1'b0, 1'b1, 3'b000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'h00A5_0533, 1'b0, 1'b0, 3'b000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h40A5_0533, 1'b1, 1'b0, 3'b001, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'hFE05_1EE3, 1'b0, 1'b0, 3'b001, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{32'hFE05_1EE3, 1'b1, 1'b0, 3'b001, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{32'h0010_0013, 1'b0, 1'b1, 3'b000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'h0020_9463, 1'b0, 1'b0, 3'b001, 32'h0000_0008, 1'b0, 1'b1, 1'b1, 1'b0};
`ifdef RED_SEQ_ILLEGAL_TRAP_EN
        vecs[8] = '{32'h0000_007F, 1'b0, 1'b0, 3'b000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        vecs[8] = '{32'h0000_007F, 1'b0, 1'b0, 3'b000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_in    = 32'd0;
        EQ          = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_instr", 0, Instr, 32'd0);
        check("rst_ctrl", 0, {27'd0, ALUsrc, ALUctrl, RegWrite}, 32'd0);
        check("rst_imm", 0, ImmOp, 32'd0);
        check("rst_flags", 0, {28'd0, branch_valid, branch_taken, done, illegal}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_next", 0, {31'd0, instr_ready}, 32'd1);

        // Back-to-back ADDI with valid held high: handshakes 4 cycles apart
        instr_in    = 32'h0050_0513;
        instr_valid = 1'b1;
        t1 = -1; t2 = -1; ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (done) ndone++;
            if (instr_ready) begin
                if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
            end
        end
        instr_valid = 1'b0;
        check("b2b_first", 0, t1, 0);
        check("b2b_spacing", 0, t2 - t1, 4);
        check("b2b_done_cnt", 0, ndone, 3);

        // Reset in the middle of EXEC of an ADD
        n = 0;
        @(negedge clk);
        instr_in    = 32'h00A5_0533;
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_ready_wait", 0, {31'd0, instr_ready}, 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_instr", 0, Instr, 32'd0);
        check("mid_ctrl", 0, {26'd0, instr_ready, ALUsrc, ALUctrl, RegWrite}, 32'd0);
        check("mid_flags", 0, {28'd0, branch_valid, branch_taken, done, illegal}, 32'd0);
        nrw = 0;
        repeat (2) begin
            @(negedge clk);
            if (RegWrite) nrw++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (RegWrite) nrw++;
        end
        check("mid_no_write", 0, nrw, 0);
        check("mid_ready_after", 0, {31'd0, instr_ready}, 32'd1);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            run_vec(v, i);
        end

`ifdef RED_SEQ_ILLEGAL_TRAP_EN
        // Parked in trap: illegal sticky and no further handshakes
        instr_in    = 32'h0050_0513;
        instr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("trap_ready", i, {31'd0, instr_ready}, 32'd0);
            check("trap_illegal", i, {31'd0, illegal}, 32'd1);
            check("trap_rw", i, {31'd0, RegWrite}, 32'd0);
        end
        instr_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("trap_rst_illegal", 0, {31'd0, illegal}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("trap_rst_ready", 0, {31'd0, instr_ready}, 32'd1);
`else
        // Illegal retired as NOP; sequencer keeps working
        v = vecs[0];
        run_vec(v, 9);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
